// File: rtl/req_ack_32bit_receiver_pkg.sv
// Shared definitions for the 32-bit request/acknowledge receive path:
// link FSM encoding, word/frame widths and the frame packing helper.
package req_ack_32bit_receiver_pkg;

    localparam int unsigned LINK_W  = 32;
    localparam int unsigned FRAME_W = 64;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_IDLE     = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_WAIT_REL = 2'd3
    } link_state_e;

    // Places the first link word of a pair in the upper or lower half of the frame.
    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic [LINK_W-1:0] first_word,
        input logic [LINK_W-1:0] second_word,
        input logic              high_first
    );
        logic [FRAME_W-1:0] frame;
        if (high_first) begin
            frame = {first_word, second_word};
        end else begin
            frame = {second_word, first_word};
        end
        return frame;
    endfunction

endpackage

// File: rtl/req_ack_32bit_receiver_if.sv
// Link and AXI-Stream signals of the receiver grouped as one bundle.
// master: the receiver (consumes the link, sources the stream).
// slave : the environment (drives the link, sinks the stream).
interface req_ack_32bit_receiver_if;
    import req_ack_32bit_receiver_pkg::*;

    logic                request;
    logic [LINK_W-1:0]   din;
    logic                acknowledge;
    logic                m_axis_tvalid;
    logic                m_axis_tready;
    logic [FRAME_W-1:0]  m_axis_tdata;
    logic                m_axis_tlast;

    modport master (
        input  request,
        input  din,
        output acknowledge,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tdata,
        output m_axis_tlast
    );

    modport slave (
        output request,
        output din,
        input  acknowledge,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tlast
    );

endinterface

// File: rtl/req_ack_32bit_receiver_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous control bit.
// RESET_VAL selects what the chain reports while and just after reset.
module sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_r <= {STAGES{RESET_VAL}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/req_ack_32bit_receiver.sv
// Receive side of the 32-bit request/acknowledge link. Words are taken with a
// 4-phase handshake, paired into 64-bit frames and offered on an AXI-Stream
// master port; tlast follows a programmable packet length.
module req_ack_32bit_receiver
    import req_ack_32bit_receiver_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          HIGH_FIRST  = 1'b1
) (
    input  logic                         s_axis_aclk,
    input  logic                         s_axis_aresetn,
    req_ack_32bit_receiver_if.master     bus,
    input  logic [31:0]                  recv_len,
    output logic [31:0]                  beat_cnt,
    output logic [31:0]                  tlast_cnt
);

    logic               req_s;
    link_state_e        state_r;
    link_state_e        state_nxt_s;
    logic               ack_r;
    logic [LINK_W-1:0]  half_q_r;
    logic               half_v_r;
    logic               tvalid_r;
    logic               tlast_r;
    logic [FRAME_W-1:0] tdata_r;
    logic [31:0]        pkt_idx_r;
    logic [31:0]        pkt_idx_nxt_s;
    logic [31:0]        beat_cnt_r;
    logic [31:0]        tlast_cnt_r;
    logic               hs_s;
    logic               can_take_s;
    logic               capture_s;
    logic               load_s;
    logic               tlast_new_s;

    // The synchronizer resets to 1 so a request still high from before reset
    // keeps the FSM in INIT until the sender has visibly released it.
    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_req_sync (
        .clk   (s_axis_aclk),
        .rst_n (s_axis_aresetn),
        .d     (bus.request),
        .q     (req_s)
    );

    assign hs_s       = tvalid_r & bus.m_axis_tready;
    assign can_take_s = (~half_v_r) | (~tvalid_r) | hs_s;
    assign capture_s  = (state_r == ST_CAPTURE);
    assign load_s     = capture_s & half_v_r;

    // Link FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (!req_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (req_s && can_take_s) begin
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                state_nxt_s = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (!req_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_REL;
                end
            end
            default: begin
                state_nxt_s = ST_INIT;
            end
        endcase
    end

    // Link FSM state register; acknowledge is registered from the next state so
    // it rises on the edge that enters CAPTURE and falls on the edge leaving WAIT_REL.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_r <= ST_INIT;
            ack_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ack_r   <= (state_nxt_s == ST_CAPTURE) || (state_nxt_s == ST_WAIT_REL);
        end
    end

    // Packet index as it will stand after this cycle's handshake; tlast of a
    // newly loaded beat is derived from it so a same-cycle drain is accounted for.
    always_comb begin
        pkt_idx_nxt_s = pkt_idx_r;
        if (hs_s) begin
            if (tlast_r) begin
                pkt_idx_nxt_s = 32'd0;
            end else begin
                pkt_idx_nxt_s = pkt_idx_r + 32'd1;
            end
        end else begin
            pkt_idx_nxt_s = pkt_idx_r;
        end
        tlast_new_s = (recv_len != 32'd0) && (pkt_idx_nxt_s == (recv_len - 32'd1));
    end

    // Half-word slot: first word of a pair waits here for its partner.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            half_q_r <= '0;
            half_v_r <= 1'b0;
        end else if (capture_s) begin
            if (half_v_r) begin
                half_v_r <= 1'b0;
            end else begin
                half_q_r <= bus.din;
                half_v_r <= 1'b1;
            end
        end else begin
            half_v_r <= half_v_r;
        end
    end

    // Single-entry output register; a load wins over a drain in the same cycle.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            tdata_r  <= '0;
        end else if (load_s) begin
            tvalid_r <= 1'b1;
            tlast_r  <= tlast_new_s;
            tdata_r  <= pack_frame(half_q_r, bus.din, HIGH_FIRST);
        end else if (hs_s) begin
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
        end else begin
            tvalid_r <= tvalid_r;
        end
    end

    // Packet index and handoff statistics, advanced only on completed handshakes.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            pkt_idx_r   <= 32'd0;
            beat_cnt_r  <= 32'd0;
            tlast_cnt_r <= 32'd0;
        end else if (hs_s) begin
            pkt_idx_r   <= pkt_idx_nxt_s;
            beat_cnt_r  <= beat_cnt_r + 32'd1;
            tlast_cnt_r <= tlast_cnt_r + {31'd0, tlast_r};
        end else begin
            pkt_idx_r   <= pkt_idx_r;
        end
    end

    assign bus.acknowledge   = ack_r;
    assign bus.m_axis_tvalid = tvalid_r;
    assign bus.m_axis_tdata  = tdata_r;
    assign bus.m_axis_tlast  = tlast_r;
    assign beat_cnt          = beat_cnt_r;
    assign tlast_cnt         = tlast_cnt_r;

endmodule

// File: tb/tb_req_ack_32bit_receiver.sv
// Self-checking bench for req_ack_32bit_receiver. Two instances share the same
// link stimulus: dut0 with HIGH_FIRST=1, dut1 with HIGH_FIRST=0. Expected beats
// come from a vector table and are queued when the second word is sent, then
// popped by a monitor when a stream handshake is about to complete.
module tb_req_ack_32bit_receiver;
    import req_ack_32bit_receiver_pkg::*;

    localparam int SYNC   = 2;
    localparam int BUDGET = 40;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [63:0] exp_data;
        logic        exp_last;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] recv_len;
    logic [31:0] bc0, tc0, bc1, tc1;

    int checks = 0;
    int errors = 0;

    vec_t vtab [0:17];
    exp_t exp0_q [$];
    exp_t exp1_q [$];
    exp_t e0, e1;

    req_ack_32bit_receiver_if bus0 ();
    req_ack_32bit_receiver_if bus1 ();

    assign bus1.request       = bus0.request;
    assign bus1.din           = bus0.din;
    assign bus1.m_axis_tready = bus0.m_axis_tready;

    req_ack_32bit_receiver #(.SYNC_STAGES(SYNC), .HIGH_FIRST(1'b1)) dut0 (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .bus            (bus0),
        .recv_len       (recv_len),
        .beat_cnt       (bc0),
        .tlast_cnt      (tc0)
    );

    req_ack_32bit_receiver #(.SYNC_STAGES(SYNC), .HIGH_FIRST(1'b0)) dut1 (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .bus            (bus1),
        .recv_len       (recv_len),
        .beat_cnt       (bc1),
        .tlast_cnt      (tc1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: the stream inputs only change just after a rising edge, so a
    // valid&ready seen here is the handshake of the next rising edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus0.m_axis_tvalid && bus0.m_axis_tready) begin
                if (exp0_q.size() == 0) begin
                    check("beat0_unexpected", bus0.m_axis_tdata, 64'hx);
                end else begin
                    e0 = exp0_q.pop_front();
                    check("beat0_tdata", bus0.m_axis_tdata, e0.d);
                    check("beat0_tlast", {63'd0, bus0.m_axis_tlast}, {63'd0, e0.l});
                end
            end
            if (bus1.m_axis_tvalid && bus1.m_axis_tready) begin
                if (exp1_q.size() == 0) begin
                    check("beat1_unexpected", bus1.m_axis_tdata, 64'hx);
                end else begin
                    e1 = exp1_q.pop_front();
                    check("beat1_tdata", bus1.m_axis_tdata, e1.d);
                    check("beat1_tlast", {63'd0, bus1.m_axis_tlast}, {63'd0, e1.l});
                end
            end
        end
    end

    task automatic push_exp(input int idx);
        exp_t t;
        t.d = vtab[idx].exp_data;
        t.l = vtab[idx].exp_last;
        exp0_q.push_back(t);
        t.d = {vtab[idx].exp_data[31:0], vtab[idx].exp_data[63:32]};
        exp1_q.push_back(t);
    endtask

    // Waits for acknowledge to reach 'want'; cyc is the number of rising edges taken.
    task automatic wait_ack(input logic want, input int budget, output int cyc);
        cyc = -1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk);
            #1;
            if (bus0.acknowledge === want) begin
                cyc = n;
                break;
            end
        end
        if (cyc < 0) begin
            check("ack_wait", {63'd0, bus0.acknowledge}, {63'd0, want});
        end
    endtask

    task automatic send_word(input logic [31:0] w, output int rise, output int fall);
        @(negedge clk);
        bus0.din     = w;
        bus0.request = 1'b1;
        wait_ack(1'b1, BUDGET, rise);
        @(negedge clk);
        bus0.request = 1'b0;
        wait_ack(1'b0, BUDGET, fall);
    endtask

    task automatic send_pair(input int idx);
        int r, f;
        send_word(vtab[idx].w0, r, f);
        push_exp(idx);
        send_word(vtab[idx].w1, r, f);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp0_q.size() != 0 || exp1_q.size() != 0) && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("queue_empty", 64'(exp0_q.size() + exp1_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        exp0_q.delete();
        exp1_q.delete();
        rst_n = 1'b1;
        repeat (SYNC + 3) @(negedge clk);
    endtask

    initial begin
        int rise, fall, n;
        logic [8:0] last_mask;

        // Vector table: index 0 single frame, 1..9 recv_len=3 run, 10..11
        // backpressure words, 12 post-reset pair, 13..17 recv_len=0 run.
        vtab[0] = '{32'hAAAA0001, 32'h55550002, 64'hAAAA0001_55550002, 1'b1};
        last_mask = 9'b100_100_100;
        for (int i = 0; i < 9; i++) begin
            vtab[1+i].w0       = 32'h1000_0000 + 32'(i);
            vtab[1+i].w1       = 32'h2000_0000 + 32'(i);
            vtab[1+i].exp_data = {vtab[1+i].w0, vtab[1+i].w1};
            vtab[1+i].exp_last = last_mask[i];
        end
        vtab[10] = '{32'hB000_0001, 32'hB000_0002, 64'hB000_0001_B000_0002, 1'b0};
        vtab[11] = '{32'hB000_0003, 32'hB000_0004, 64'hB000_0003_B000_0004, 1'b0};
        vtab[12] = '{32'hC0DE_0001, 32'hC0DE_0002, 64'hC0DE_0001_C0DE_0002, 1'b1};
        for (int i = 0; i < 5; i++) begin
            vtab[13+i].w0       = 32'hD000_0000 + 32'(2*i);
            vtab[13+i].w1       = 32'hD000_0001 + 32'(2*i);
            vtab[13+i].exp_data = {vtab[13+i].w0, vtab[13+i].w1};
            vtab[13+i].exp_last = 1'b0;
        end

        rst_n              = 1'b0;
        recv_len           = 32'd1;
        bus0.request       = 1'b0;
        bus0.din           = 32'd0;
        bus0.m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset values.
        check("rst_ack",    {63'd0, bus0.acknowledge},   64'd0);
        check("rst_tvalid", {63'd0, bus0.m_axis_tvalid}, 64'd0);
        check("rst_tlast",  {63'd0, bus0.m_axis_tlast},  64'd0);
        check("rst_tdata",  bus0.m_axis_tdata,           64'd0);
        check("rst_beat",   {32'd0, bc0},                64'd0);
        check("rst_tlastc", {32'd0, tc0},                64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (SYNC + 3) @(negedge clk);

        // Single frame, recv_len=1, with handshake latency checks on the first word.
        send_word(vtab[0].w0, rise, fall);
        check("ack_rise_lat", 64'(rise), 64'(SYNC + 1));
        check("ack_fall_lat", 64'(fall), 64'(SYNC + 1));
        push_exp(0);
        send_word(vtab[0].w1, rise, fall);
        wait_drain();
        check("t1_beat",  {32'd0, bc0}, 64'd1);
        check("t1_tlast", {32'd0, tc0}, 64'd1);

        // recv_len=3: eight frames, then a ninth that must close the third packet.
        do_reset();
        recv_len = 32'd3;
        for (int i = 1; i <= 8; i++) begin
            send_pair(i);
        end
        wait_drain();
        check("t2_beat",   {32'd0, bc0}, 64'd8);
        check("t2_tlast",  {32'd0, tc0}, 64'd2);
        check("t2_beat1",  {32'd0, bc1}, 64'd8);
        send_pair(9);
        wait_drain();
        check("t2_beat9",  {32'd0, bc0}, 64'd9);
        check("t2_tlast9", {32'd0, tc0}, 64'd3);

        // Backpressure: one full frame in the output register plus one half word
        // fill the receiver, so the fourth word must stall until tready returns.
        do_reset();
        recv_len = 32'd0;
        @(posedge clk);
        #1;
        bus0.m_axis_tready = 1'b0;
        send_word(vtab[10].w0, rise, fall);
        push_exp(10);
        send_word(vtab[10].w1, rise, fall);
        send_word(vtab[11].w0, rise, fall);
        push_exp(11);
        @(negedge clk);
        bus0.din     = vtab[11].w1;
        bus0.request = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("bp_no_ack",  {63'd0, bus0.acknowledge},   64'd0);
        check("bp_tvalid",  {63'd0, bus0.m_axis_tvalid}, 64'd1);
        check("bp_tdata0",  bus0.m_axis_tdata, vtab[10].exp_data);
        check("bp_tdata1",  bus1.m_axis_tdata, {vtab[10].exp_data[31:0], vtab[10].exp_data[63:32]});
        check("bp_beat",    {32'd0, bc0}, 64'd0);
        @(posedge clk);
        #1;
        bus0.m_axis_tready = 1'b1;
        wait_ack(1'b1, SYNC + 2, n);
        check("bp_ack_after", {63'd0, bus0.acknowledge}, 64'd1);
        @(negedge clk);
        bus0.request = 1'b0;
        wait_ack(1'b0, BUDGET, n);
        wait_drain();
        check("bp_beat_end", {32'd0, bc0}, 64'd2);

        // Reset while request is high on the second word of a pair.
        do_reset();
        recv_len = 32'd1;
        send_word(32'hDEAD_0001, rise, fall);
        @(negedge clk);
        bus0.din     = 32'hDEAD_0002;
        bus0.request = 1'b1;
        wait_ack(1'b1, BUDGET, n);
        #3;
        rst_n = 1'b0;
        #1;
        check("mr_ack_async", {63'd0, bus0.acknowledge},   64'd0);
        check("mr_tvalid",    {63'd0, bus0.m_axis_tvalid}, 64'd0);
        @(negedge clk);
        exp0_q.delete();
        exp1_q.delete();
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("mr_ack_held", {63'd0, bus0.acknowledge}, 64'd0);
        @(negedge clk);
        bus0.request = 1'b0;
        repeat (SYNC + 4) @(posedge clk);
        #1;
        check("mr_ack_low", {63'd0, bus0.acknowledge}, 64'd0);
        send_pair(12);
        wait_drain();
        check("mr_beat",  {32'd0, bc0}, 64'd1);
        check("mr_tlast", {32'd0, tc0}, 64'd1);

        // recv_len=0: five beats, tlast never set.
        do_reset();
        recv_len = 32'd0;
        for (int i = 13; i <= 17; i++) begin
            send_pair(i);
        end
        wait_drain();
        check("z_beat",   {32'd0, bc0}, 64'd5);
        check("z_tlast",  {32'd0, tc0}, 64'd0);
        check("z_beat1",  {32'd0, bc1}, 64'd5);
        check("z_tlast1", {32'd0, tc1}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
